sseg_scan: RTL and testbench
============================

# sseg_scan

Four-digit seven-segment scan driver for the Basys3 display, directly downstream of the ready/set/go message stage. Consumes that stage's four 4-bit glyph codes and per-digit blank mask, snapshots them once per refresh frame so a message change never tears mid-frame, and time-multiplexes them onto the active-low anode and segment pins. A short all-anodes-off guard interval between digits suppresses ghosting.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥ 2.
- GUARD_CYC, 16: cycles at the start of each slot with all anodes off; legal range 0 ≤ GUARD_CYC < REFRESH_DIV.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- A  input  4  glyph code, leftmost digit (an[3]).
- B  input  4  glyph code, an[2].
- C  input  4  glyph code, an[1].
- D  input  4  glyph code, rightmost digit (an[0]).
- blank  input  4  per-digit blank mask, 1 = dark; blank[3]→A … blank[0]→D.
- an  output  4  anode enables, active-low, registered.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low; constant 1 (off).
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (2 bits, 0=A,1=B,2=C,3=D), shadow registers sA..sD and sblank, flag first.
- Reset (reset==0 at an edge): cnt=0, idx=0, sA..sD=0, sblank=4'b1111, first=1, an=4'b1111, seg=7'b1111111, dp=1, frame_start=0. Reset mid-frame aborts the slot immediately; nothing carries over.
- Counter: cnt==REFRESH_DIV-1 → cnt=0, idx=idx+1 (3 wraps to 0); else cnt=cnt+1.
- Snapshot: shadow ← {A,B,C,D,blank} when (first==1) or (cnt==REFRESH_DIV-1 and idx==3); first clears on the first non-reset edge. Inputs are otherwise ignored; any input change is visible only from the next frame.
- frame_start registered: high for exactly the cycle following a snapshot edge (including the post-reset snapshot).
- Output register, computed from current cnt/idx/shadow: dark if cnt<GUARD_CYC or sblank[3-idx]==1 → an=4'b1111, seg=7'b1111111; else an = ~(4'b1000>>idx), seg = decode(shadow digit idx).
- Decode (lit segments; all others off): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A 'r' eg, B 'S' acdfg, C 'Y' bcdfg, D 'd' bcdeg, E 't' defg, F '-' g.
- Exactly zero or one anode low at any time.

## Timing
- an/seg lag cnt/idx by one cycle (registered outputs).
- Each digit lit for REFRESH_DIV-GUARD_CYC cycles per slot; frame period 4·REFRESH_DIV cycles.
- Post-reset: first edge with reset==1 loads shadow; outputs stay dark through the guard of slot A, then show new A.
- Input change in the cycle of a snapshot edge is captured; change one cycle later waits a full frame.
- Simultaneous snapshot and reset assertion: reset wins.

## Test plan
- REFRESH_DIV=8, GUARD_CYC=2; reset low 3 cycles → an=1111, seg=1111111, dp=1, frame_start=0 throughout.
- Release reset, A=0,B=1,C=8,D=F, blank=0000 → frame_start pulse 1 cycle after release; an sequence 0111/1011/1101/1110, each low 6 of 8 cycles with 2 dark guard cycles; seg 1000000, 1111001, 0000000, 0111111.
- blank=1000, B=A,C=D,D=C (“rdY”) → an[3] never low; seg 0101111, 0100001, 0010001 on an 1011/1101/1110.
- Change A mid-frame (during slot C) → digit A shows old code until frame_start, new code in the following slot A; no mixed frame.
- Assert reset during slot C lit phase → next cycle an=1111, seg=1111111; after release scan restarts at slot A with freshly sampled inputs.
- GUARD_CYC=0 → digit lit all 8 cycles; anode transitions directly from one digit to the next with never two anodes low.

Source files
------------

// File: rtl/sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan
//  Purpose  : Four-digit seven-segment scan driver with per-frame input
//             snapshot and an all-anodes-off guard at the start of each slot.
//  Revision : 1.0
// ============================================================================
module sseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GUARD_C  = CW'(GUARD_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    sdig [4];
  logic [3:0]    sblank;
  logic          first;

  logic          slot_end;
  logic          snap;
  logic          dark;
  logic [3:0]    cur_dig;

  function automatic logic [6:0] decode(input logic [3:0] g);
    logic [6:0] s;
    case (g)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0101111;  // r
      4'hB: s = 7'b0010010;  // S
      4'hC: s = 7'b0010001;  // Y
      4'hD: s = 7'b0100001;  // d
      4'hE: s = 7'b0000111;  // t
      4'hF: s = 7'b0111111;  // -
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end = (cnt == CNT_LAST);
    snap     = first || (slot_end && (idx == 2'd3));
    cur_dig  = sdig[idx];
    // blank[3] belongs to A (idx 0), so the mask is read reversed
    dark     = (cnt < GUARD_C) || sblank[2'd3 - idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      idx         <= 2'd0;
      sdig[0]     <= 4'h0;
      sdig[1]     <= 4'h0;
      sdig[2]     <= 4'h0;
      sdig[3]     <= 4'h0;
      sblank      <= 4'b1111;
      first       <= 1'b1;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      frame_start <= 1'b0;
    end else begin
      first       <= 1'b0;
      frame_start <= snap;
      if (snap) begin
        sdig[0] <= A;
        sdig[1] <= B;
        sdig[2] <= C;
        sdig[3] <= D;
        sblank  <= blank;
      end
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (dark) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end else begin
        an  <= ~(4'b1000 >> idx);
        seg <= decode(cur_dig);
      end
    end
  end

  assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan
//  Purpose  : Randomized self-checking bench for sseg_scan (guard 2 and 0).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sseg_scan;

  localparam int RD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] a = 4'h0, b = 4'h0, c = 4'h0, d = 4'h0, blank = 4'h0;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fs0, fs1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sseg_scan #(.REFRESH_DIV(RD), .GUARD_CYC(2)) u_g2 (
    .clk(clk), .reset(reset), .A(a), .B(b), .C(c), .D(d), .blank(blank),
    .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
  );

  sseg_scan #(.REFRESH_DIV(RD), .GUARD_CYC(0)) u_g0 (
    .clk(clk), .reset(reset), .A(a), .B(b), .C(c), .D(d), .blank(blank),
    .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  // Lit segment letters per glyph code
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "eg", "acdfg", "bcdfg", "bcdeg", "defg", "g"};

  function automatic logic [6:0] ref_seg(input logic [3:0] g);
    logic [6:0] s;
    string t;
    s = 7'h7F;
    t = lit[g];
    for (int i = 0; i < t.len(); i++) s[int'(t[i]) - 97] = 1'b0;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k = clock edges since reset release
  int         k;
  int         gcyc [2] = '{2, 0};
  int         slot_pos, digit;
  logic [3:0] m_dig [4];
  logic [3:0] m_blank;
  logic [3:0] exp_an [2];
  logic [6:0] exp_seg [2];
  logic       exp_fs;

  always @(posedge clk) begin
    if (!reset) begin
      k = 0;
      m_blank = 4'hF;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      for (int g = 0; g < 2; g++) begin
        exp_an[g]  = 4'hF;
        exp_seg[g] = 7'h7F;
      end
      exp_fs = 1'b0;
    end else begin
      slot_pos = k % RD;
      digit    = (k / RD) % 4;
      for (int g = 0; g < 2; g++) begin
        exp_an[g]  = 4'hF;
        exp_seg[g] = 7'h7F;
        if (slot_pos >= gcyc[g] && !m_blank[3 - digit]) begin
          exp_an[g][3 - digit] = 1'b0;
          exp_seg[g] = ref_seg(m_dig[digit]);
        end
      end
      exp_fs = (k == 0) || (k % (4 * RD) == 4 * RD - 1);
      if (exp_fs) begin
        m_dig[0] = a; m_dig[1] = b; m_dig[2] = c; m_dig[3] = d;
        m_blank = blank;
      end
      k++;
    end
  end

  always @(posedge clk) begin
    #1;
    check("an_g2", an0, exp_an[0]);
    check("seg_g2", seg0, exp_seg[0]);
    check("fs_g2", fs0, exp_fs);
    check("an_g0", an1, exp_an[1]);
    check("seg_g0", seg1, exp_seg[1]);
    check("fs_g0", fs1, exp_fs);
    check("dp", {dp1, dp0}, 2'b11);
    check("onehot", ($countones(~an0) <= 1) && ($countones(~an1) <= 1), 1);
  end

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the outputs shown belong to post-release cycle n
  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (k != n + 1 && guard < 500) begin
      wait_n(1);
      guard++;
    end
    if (k != n + 1) begin
      errors++;
      $display("FAIL goto_timeout: got %0d expected %0d", k - 1, n);
    end
  endtask

  initial begin
    repeat (3) begin
      wait_n(1);
      check("rst_an", an0, 4'b1111);
      check("rst_seg", seg0, 7'b1111111);
      check("rst_fs", fs0, 1'b0);
    end

    a = 4'h0; b = 4'h1; c = 4'h8; d = 4'hF; blank = 4'b0000;
    reset = 1'b1;
    wait_n(1);
    check("post_rst_fs", fs0, 1'b1);
    goto(1);
    check("guard_a_an", an0, 4'b1111);
    check("g0_a_an", an1, 4'b0111);
    goto(4);
    check("dig0_an", an0, 4'b0111);
    check("dig0_seg", seg0, 7'b1000000);
    goto(12);
    check("dig1_an", an0, 4'b1011);
    check("dig1_seg", seg0, 7'b1111001);
    goto(20);
    check("dig8_an", an0, 4'b1101);
    check("dig8_seg", seg0, 7'b0000000);
    a = 4'h5; b = 4'hA; c = 4'hD; d = 4'hC; blank = 4'b1000;
    goto(28);
    check("digF_an", an0, 4'b1110);
    check("digF_seg", seg0, 7'b0111111);
    goto(31);
    check("frame_fs", fs0, 1'b1);
    goto(36);
    check("blankA_an", an0, 4'b1111);
    goto(44);
    check("r_an", an0, 4'b1011);
    check("r_seg", seg0, 7'b0101111);
    goto(52);
    check("d_an", an0, 4'b1101);
    check("d_seg", seg0, 7'b0100001);
    goto(60);
    check("Y_an", an0, 4'b1110);
    check("Y_seg", seg0, 7'b0010001);

    goto(66);
    blank = 4'b0000; a = 4'h7;
    goto(100);
    check("a7_seg", seg0, 7'b1111000);
    goto(116);
    a = 4'h3;
    goto(132);
    check("a3_seg", seg0, 7'b0110000);

    goto(148);
    reset = 1'b0;
    wait_n(1);
    check("midrst_an", an0, 4'b1111);
    check("midrst_seg", seg0, 7'b1111111);
    a = 4'h9; b = 4'h2; c = 4'h6; d = 4'hE;
    reset = 1'b1;
    wait_n(1);
    check("rerel_fs", fs0, 1'b1);
    goto(4);
    check("rs9_an", an0, 4'b0111);
    check("rs9_seg", seg0, 7'b0010000);
    goto(12);
    check("rs2_seg", seg0, 7'b0100100);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
        blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      wait_n(1);
    end
    reset = 1'b1;
    wait_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
